twiddle_addr_gen_unit: RTL

TWIDDLE_ADDR_GEN_UNIT -- requirements
Module: twiddle_addr_gen_unit

---
 rtl/twiddle_addr_gen_unit_pkg.sv | 19 +
 rtl/fft_bit_insert.sv | 20 ++
 rtl/twiddle_addr_gen_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/twiddle_addr_gen_unit_pkg.sv
// Shared FFT definitions: twiddle table parameters, address-generator FSM
// encoding and the stage-counter width helper.
package twiddle_addr_gen_unit_pkg;

    localparam int unsigned TABLE_DIVISION = 2;
    localparam int unsigned AWL_MIN        = 2;
    localparam int unsigned AWL_MAX        = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_e;

    // Bits needed to hold a stage index 0..awl-1.
    function automatic int unsigned stage_width(input int unsigned awl);
        return (awl < 2) ? 1 : $clog2(awl);
    endfunction

endpackage

// File: rtl/fft_bit_insert.sv
// Inserts a zero bit into val_i at position pos_i, shifting the upper bits up by one.
module fft_bit_insert #(
    parameter int unsigned AW = 4,
    parameter int unsigned SW = 2
) (
    input  logic [AW-2:0] val_i,
    input  logic [SW-1:0] pos_i,
    output logic [AW-1:0] ins_c_o
);

    logic [AW-1:0] val_ext;
    logic [AW-1:0] low_mask;

    always_comb begin
        val_ext  = AW'(val_i);
        low_mask = (AW'(1) << pos_i) - AW'(1);
        ins_c_o  = ((val_ext & ~low_mask) << 1) | (val_ext & low_mask);
    end

endmodule

// File: rtl/twiddle_addr_gen_unit.sv
// Radix-2 DIT address sequencer: walks every butterfly of every stage and
// presents registered data-RAM operand addresses plus the twiddle table index.
module twiddle_addr_gen_unit
    import twiddle_addr_gen_unit_pkg::*;
#(
    parameter int unsigned AWL = 4,
    parameter int unsigned TWL = AWL - 1
) (
    input  logic                        i_CLK,
    input  logic                        i_RST_N,
    input  logic                        i_START,
    input  logic                        i_READY,
    output logic                        o_VALID,
    output logic [AWL-1:0]              o_ADDR_A,
    output logic [AWL-1:0]              o_ADDR_B,
    output logic [TWL-1:0]              o_TW_ADDR,
    output logic [stage_width(AWL)-1:0] o_STAGE,
    output logic                        o_BUSY,
    output logic                        o_DONE
);

    localparam int unsigned KW = AWL - 1;
    localparam int unsigned SW = stage_width(AWL);
    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(AWL - 1);

    fsm_state_e     state_q, state_d;
    logic [SW-1:0]  s_q, s_d;
    logic [KW-1:0]  k_q, k_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [AWL-1:0] addr_a_q, addr_a_d;
    logic [AWL-1:0] addr_b_q, addr_b_d;
    logic [TWL-1:0] tw_q, tw_d;

    logic [AWL-1:0] ins_addr_c;
    logic [KW-1:0]  j_mask;
    logic [KW-1:0]  j_val;
    logic [SW-1:0]  tw_shift;

    // Sequencing: one butterfly per accepted set, stages back to back.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_START) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    k_d     = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (valid_q && i_READY) begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (s_q == S_LAST) begin
                            state_d = ST_IDLE;
                            s_d     = '0;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    fft_bit_insert #(
        .AW (AWL),
        .SW (SW)
    ) u_bit_insert (
        .val_i   (k_d),
        .pos_i   (s_d),
        .ins_c_o (ins_addr_c)
    );

    // Address set for the next cycle; zero whenever no set will be presented.
    always_comb begin
        j_mask   = (KW'(1) << s_d) - KW'(1);
        j_val    = k_d & j_mask;
        tw_shift = S_LAST - s_d;
        addr_a_d = '0;
        addr_b_d = '0;
        tw_d     = '0;
        if (valid_d) begin
            addr_a_d = ins_addr_c;
            addr_b_d = ins_addr_c + (AWL'(1) << s_d);
            tw_d     = TWL'(j_val << tw_shift);
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            k_q      <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            k_q      <= k_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

    assign o_VALID   = valid_q;
    assign o_ADDR_A  = addr_a_q;
    assign o_ADDR_B  = addr_b_q;
    assign o_TW_ADDR = tw_q;
    assign o_STAGE   = s_q;
    assign o_BUSY    = busy_q;
    assign o_DONE    = done_q;

endmodule
